// File: rtl/match_timer_ctrl.sv
// Match countdown controller for the pong game: owns the configured match length
// and runs a 1 Hz countdown through IDLE/RUNNING/PAUSED/EXPIRED.
module match_timer_ctrl #(
    parameter int TICK_DIV = 100000000,
    parameter int T_MIN    = 30,
    parameter int T_MAX    = 180,
    parameter int T_STEP   = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_add,
    input  logic       btn_sub,
    input  logic       btn_start,
    input  logic       btn_pause,
    input  logic       timer_en,
    output logic [7:0] max_time,
    output logic [7:0] time_left,
    output logic       running,
    output logic       time_up,
    output logic [1:0] state
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RUNNING = 2'd1;
    localparam logic [1:0] S_PAUSED  = 2'd2;
    localparam logic [1:0] S_EXPIRED = 2'd3;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    // Button vectors are packed as {add, sub, start, pause}.
    logic [3:0]    r_sync1;
    logic [3:0]    r_sync2;
    logic [3:0]    r_prev;
    logic [1:0]    r_state;
    logic [7:0]    r_max;
    logic [7:0]    r_time_left;
    logic          r_time_up;
    logic [PW-1:0] r_presc;

    logic [3:0] w_pulse;
    logic       w_add;
    logic       w_sub;
    logic       w_start;
    logic       w_pause;
    logic       w_tick;
    logic       w_add_ok;
    logic       w_sub_ok;
    logic [7:0] w_max_next;

    assign w_pulse = r_sync2 & ~r_prev;
    assign w_add   = w_pulse[3];
    assign w_sub   = w_pulse[2];
    assign w_start = w_pulse[1];
    assign w_pause = w_pulse[0];
    assign w_tick  = (r_presc == PW'(TICK_DIV - 1));

    // Bounds are checked in 9 bits so the step can never wrap the 8-bit value.
    assign w_add_ok = ({1'b0, r_max} + 9'(T_STEP)) <= 9'(T_MAX);
    assign w_sub_ok = {1'b0, r_max} >= 9'(T_MIN + T_STEP);

    always_comb begin
        w_max_next = r_max;
        if (w_add && !w_sub && w_add_ok) begin
            w_max_next = r_max + 8'(T_STEP);
        end else if (w_sub && !w_add && w_sub_ok) begin
            w_max_next = r_max - 8'(T_STEP);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1     <= '0;
            r_sync2     <= '0;
            r_prev      <= '0;
            r_state     <= S_IDLE;
            r_max       <= 8'(T_MIN);
            r_time_left <= 8'(T_MIN);
            r_time_up   <= 1'b0;
            r_presc     <= '0;
        end else begin
            r_sync1   <= {btn_add, btn_sub, btn_start, btn_pause};
            r_sync2   <= r_sync1;
            r_prev    <= r_sync2;
            r_time_up <= 1'b0;
            if (!timer_en) begin
                r_state     <= S_IDLE;
                r_time_left <= r_max;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_max       <= w_max_next;
                        r_time_left <= w_max_next;
                        if (w_start) begin
                            r_state <= S_RUNNING;
                            r_presc <= '0;
                        end
                    end
                    S_RUNNING: begin
                        r_presc <= w_tick ? '0 : r_presc + PW'(1);
                        // A tick lands before a same-cycle pause; expiry overrides the pause.
                        if (w_tick && r_time_left <= 8'd1) begin
                            r_time_left <= 8'd0;
                            r_state     <= S_EXPIRED;
                            r_time_up   <= 1'b1;
                        end else begin
                            if (w_tick) begin
                                r_time_left <= r_time_left - 8'd1;
                            end
                            if (w_pause) begin
                                r_state <= S_PAUSED;
                            end
                        end
                    end
                    S_PAUSED: begin
                        if (w_pause) begin
                            r_state <= S_RUNNING;
                        end else if (w_start) begin
                            r_state     <= S_IDLE;
                            r_time_left <= r_max;
                        end
                    end
                    default: begin
                        r_time_left <= 8'd0;
                        if (w_start) begin
                            r_state     <= S_IDLE;
                            r_time_left <= r_max;
                        end
                    end
                endcase
            end
        end
    end

    assign max_time  = r_max;
    assign time_left = r_time_left;
    assign running   = (r_state == S_RUNNING);
    assign time_up   = r_time_up;
    assign state     = r_state;
endmodule
